freq_meter_seq: RTL and testbench
=================================

Name: freq_meter_seq

Overview:
- Measurement sequencer for the multi-channel frequency meter.
- Scans up to NCH test-clock channels round-robin and drives the channel-select mux and the reference gate window for the gate/count datapath.
- Collects the synchronized X (test) and Y (standard) counts and computes freq = CLK_STAND_FREQ*X/Y with a shared bit-serial divider, replacing a combinational divide.
- Presents each result on a valid/ready output.

Parameters:
- NCH, 4, number of test-clock channels (≥1).
- CNT_W, 48, width of the X/Y counts.
- FREQ_W, 34, result width.
- CLK_STAND_FREQ, 100_000_000, standard clock frequency in Hz.
- GATE_CYC, 100_000_000, gate_open high time in sys_clk cycles.
- SETTLE_CYC, 1024, wait after a channel switch before the gate opens.
- TIMEOUT_CYC, 200_000_000, maximum wait for cnt_valid after the gate closes.

Ports:
- sys_clk  in  1  system/standard clock.
- sys_rst_n  in  1  reset.
- enable  in  1  scanning enabled.
- ch_mask  in  NCH  channels to include in the scan.
- ch_sel  out  $clog2(NCH)  datapath test-clock mux select.
- gate_open  out  1  software gate to the datapath.
- cnt_valid  in  1  one-cycle pulse: cnt_test/cnt_stand are stable for the last gate.
- cnt_test  in  CNT_W  X count.
- cnt_stand  in  CNT_W  Y count.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_freq  out  FREQ_W  measured frequency in Hz.
- res_ch  out  $clog2(NCH)  channel the result belongs to.
- res_err  out  1  no signal (timeout or Y==0).
- res_ovf  out  1  quotient saturated.
- busy  out  1  state != IDLE.

Behaviour:
- Clocking and reset: one clock (sys_clk); reset is asynchronous and active-low (sys_rst_n).
- Reset values: all outputs 0; state IDLE; round-robin pointer = channel 0.
- FSM states: IDLE, SELECT, SETTLE, GATE, WAIT_CNT, DIV, OUT.
- IDLE: when enable=1 and ch_mask!=0, go to SELECT.
- SELECT (1 cycle):
  - Pick the first set bit of ch_mask at or after the pointer, wrapping.
  - Latch it into ch_sel and move the pointer to it+1 (mod NCH).
  - If ch_mask==0 at this point, return to IDLE.
  - ch_mask is sampled only here.
- SETTLE: counter runs SETTLE_CYC cycles, then GATE.
- GATE:
  - gate_open=1 for exactly GATE_CYC cycles, then 0; go to WAIT_CNT.
  - ch_sel is constant from SELECT through OUT.
- WAIT_CNT:
  - On a cnt_valid pulse, latch X and Y and go to DIV.
  - If TIMEOUT_CYC cycles elapse first, force res_freq=0, res_err=1 and go to OUT.
  - cnt_valid in any other state is ignored.
- DIV:
  - Y==0: res_freq=0, res_err=1, no division.
  - Otherwise the numerator N = CLK_STAND_FREQ*X is computed at full width: CNT_W+27 bits, 75 at default widths.
  - Restoring divide by Y, 1 quotient bit per cycle; DIV latency = N width + 2 cycles.
  - Quotient truncates (floor).
  - If the quotient is ≥ 2^FREQ_W, res_freq = all-ones and res_ovf=1.
- OUT:
  - res_valid=1; res_freq/res_ch/res_err/res_ovf stay stable until res_valid&&res_ready.
  - After the handshake cycle, res_valid=0 and the FSM goes to SELECT if enable=1, else IDLE.
  - res_ready while res_valid=0 has no effect.
- enable dropped in SETTLE/GATE/WAIT_CNT/DIV: abort in the next cycle.
  - gate_open=0, divider cleared, return to IDLE, no result produced.
  - In OUT, the pending result is still held until accepted.
- Reset mid-operation: immediate return to reset values; a partial result is never emitted.
- busy=1 in every state except IDLE.

Decomposition:
- Package freq_meter_pkg:
  - State enum.
  - CLK_STAND_FREQ, CNT_W, FREQ_W.
  - Derived numerator width NUM_W = CNT_W+$clog2(CLK_STAND_FREQ).
- Sub-module freq_div_seq: generic restoring divider.
  - Inputs: start, num[NUM_W], den[CNT_W].
  - Outputs: done pulse, quo[NUM_W], div0 flag.
  - Synchronous clear input for abort.
- The sequencer handles saturation to FREQ_W.

Test Plan:
(Bench parameters: GATE_CYC=1000, SETTLE_CYC=8, TIMEOUT_CYC=3000.)
1. ch_mask=4'b0101, enable=1, model returns X=500, Y=1000 -> results in order ch 0, 2, 0, 2; res_freq=50_000_000, err=0, ovf=0; gate_open high exactly 1000 cycles each time.
2. cnt_valid never pulsed -> 3000 cycles after gate closes: res_valid with res_freq=0, res_err=1; scan advances to the next channel.
3. X=1000, Y=0 -> res_freq=0, res_err=1; then X=2^47, Y=1 -> res_freq=34'h3_FFFF_FFFF, res_ovf=1.
4. res_ready held low 50 cycles -> res_valid and all result fields stable for 50 cycles; no new SELECT until the handshake.
5. enable dropped mid-GATE -> gate_open=0 next cycle, busy=0, no res_valid.
   Also: sys_rst_n pulsed in DIV -> all outputs 0 and the pointer restarts at channel 0.
6. ch_mask=0 with enable=1 -> stays IDLE, busy=0.
   Also: mask changed to 4'b1000 during GATE -> next SELECT picks channel 3.

Source files
------------

// File: rtl/freq_meter_seq_pkg.sv
// Shared types and default widths for the frequency-meter measurement sequencer.
package freq_meter_pkg;

    localparam int CLK_STAND_FREQ = 100_000_000;
    localparam int CNT_W          = 48;
    localparam int FREQ_W         = 34;
    localparam int NUM_W          = CNT_W + $clog2(CLK_STAND_FREQ);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        GATE,
        WAIT_CNT,
        DIV,
        OUT
    } state_t;

    // A single-channel build still needs a 1-bit select bus.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/freq_meter_seq_if.sv
// Datapath (mux select, gate, counts) and result valid/ready signals of the sequencer.
interface freq_meter_seq_if #(
    parameter int NCH    = 4,
    parameter int CNT_W  = freq_meter_pkg::CNT_W,
    parameter int FREQ_W = freq_meter_pkg::FREQ_W
);
    import freq_meter_pkg::*;

    localparam int CH_W = ch_width(NCH);

    logic [CH_W-1:0]   ch_sel;
    logic              gate_open;
    logic              cnt_valid;
    logic [CNT_W-1:0]  cnt_test;
    logic [CNT_W-1:0]  cnt_stand;
    logic              res_valid;
    logic              res_ready;
    logic [FREQ_W-1:0] res_freq;
    logic [CH_W-1:0]   res_ch;
    logic              res_err;
    logic              res_ovf;

    modport master (
        output ch_sel, gate_open, res_valid, res_freq, res_ch, res_err, res_ovf,
        input  cnt_valid, cnt_test, cnt_stand, res_ready
    );

    modport slave (
        input  ch_sel, gate_open, res_valid, res_freq, res_ch, res_err, res_ovf,
        output cnt_valid, cnt_test, cnt_stand, res_ready
    );

endinterface

// File: rtl/freq_meter_seq_div.sv
// Restoring divider: one quotient bit per cycle, done pulses NUM_W+1 cycles after start.
module freq_div_seq #(
    parameter int NUM_W = freq_meter_pkg::NUM_W,
    parameter int DEN_W = freq_meter_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [NUM_W-1:0] quo,
    output logic             div0
);
    import freq_meter_pkg::*;

    localparam int BC_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] quo_reg;
    logic [DEN_W-1:0] rem_reg;
    logic [DEN_W-1:0] den_reg;
    logic [BC_W-1:0]  bit_cnt_reg;
    logic             run_reg;
    logic             done_reg;
    logic             div0_reg;

    logic [DEN_W:0]   shifted;
    logic [DEN_W:0]   diff;
    logic             fits;

    // quo_reg shifts numerator bits out of the top while quotient bits enter at the bottom.
    assign shifted = {rem_reg, quo_reg[NUM_W-1]};
    assign fits    = (shifted >= {1'b0, den_reg});
    assign diff    = shifted - {1'b0, den_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_reg     <= '0;
            rem_reg     <= '0;
            den_reg     <= '0;
            bit_cnt_reg <= '0;
            run_reg     <= 1'b0;
            done_reg    <= 1'b0;
            div0_reg    <= 1'b0;
        end else if (clear) begin
            quo_reg     <= '0;
            rem_reg     <= '0;
            bit_cnt_reg <= '0;
            run_reg     <= 1'b0;
            done_reg    <= 1'b0;
            div0_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                if (den == '0) begin
                    quo_reg  <= '0;
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                    div0_reg <= 1'b1;
                end else begin
                    quo_reg     <= num;
                    rem_reg     <= '0;
                    den_reg     <= den;
                    bit_cnt_reg <= BC_W'(NUM_W);
                    run_reg     <= 1'b1;
                    div0_reg    <= 1'b0;
                end
            end else if (run_reg) begin
                quo_reg     <= {quo_reg[NUM_W-2:0], fits};
                rem_reg     <= fits ? diff[DEN_W-1:0] : shifted[DEN_W-1:0];
                bit_cnt_reg <= bit_cnt_reg - 1'b1;
                if (bit_cnt_reg == BC_W'(1)) begin
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done = done_reg;
    assign quo  = quo_reg;
    assign div0 = div0_reg;

endmodule

// File: rtl/freq_meter_seq.sv
// Round-robin measurement sequencer: selects a channel, times settle/gate, divides CLK*X/Y.
module freq_meter_seq #(
    parameter int NCH            = 4,
    parameter int CNT_W          = freq_meter_pkg::CNT_W,
    parameter int FREQ_W         = freq_meter_pkg::FREQ_W,
    parameter int CLK_STAND_FREQ = freq_meter_pkg::CLK_STAND_FREQ,
    parameter int GATE_CYC       = 100_000_000,
    parameter int SETTLE_CYC     = 1024,
    parameter int TIMEOUT_CYC    = 200_000_000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  enable,
    input  logic [NCH-1:0]        ch_mask,
    output logic                  busy,
    freq_meter_seq_if.master      bus
);
    import freq_meter_pkg::*;

    localparam int CH_W  = ch_width(NCH);
    localparam int NUM_W = CNT_W + $clog2(CLK_STAND_FREQ);

    state_t            state_reg,    state_next;
    logic [CH_W-1:0]   ptr_reg,      ptr_next;
    logic [CH_W-1:0]   ch_sel_reg,   ch_sel_next;
    logic [31:0]       tmr_reg,      tmr_next;
    logic [CNT_W-1:0]  x_reg,        x_next;
    logic [CNT_W-1:0]  y_reg,        y_next;
    logic [FREQ_W-1:0] freq_reg,     freq_next;
    logic              err_reg,      err_next;
    logic              ovf_reg,      ovf_next;
    logic              start_reg,    start_next;

    logic              div_clear;
    logic              div_done;
    logic              div_zero;
    logic [NUM_W-1:0]  div_quo;
    logic [NUM_W-1:0]  num;
    logic [CH_W-1:0]   pick;

    function automatic logic [CH_W-1:0] first_from(input logic [NCH-1:0] mask,
                                                   input logic [CH_W-1:0] from);
        logic [CH_W-1:0] sel;
        logic [CH_W-1:0] idx_c;
        logic            found;
        int              idx;
        sel   = from;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(from) + i;
            if (idx >= NCH) idx = idx - NCH;
            idx_c = CH_W'(idx);
            if (!found && mask[idx_c]) begin
                sel   = idx_c;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick = first_from(ch_mask, ptr_reg);
    assign num  = NUM_W'(CLK_STAND_FREQ) * NUM_W'(x_reg);

    freq_div_seq #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_W)
    ) u_div (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clear (div_clear),
        .start (start_reg),
        .num   (num),
        .den   (y_reg),
        .done  (div_done),
        .quo   (div_quo),
        .div0  (div_zero)
    );

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        ch_sel_next = ch_sel_reg;
        tmr_next    = tmr_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        freq_next   = freq_reg;
        err_next    = err_reg;
        ovf_next    = ovf_reg;
        start_next  = 1'b0;
        div_clear   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (enable && (ch_mask != '0)) state_next = SELECT;
            end
            SELECT: begin
                if (ch_mask == '0) begin
                    state_next = IDLE;
                end else begin
                    ch_sel_next = pick;
                    ptr_next    = (pick == CH_W'(NCH - 1)) ? '0 : pick + 1'b1;
                    tmr_next    = '0;
                    state_next  = SETTLE;
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (tmr_reg == 32'(SETTLE_CYC - 1)) begin
                    tmr_next   = '0;
                    state_next = GATE;
                end else begin
                    tmr_next = tmr_reg + 32'd1;
                end
            end
            GATE: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (tmr_reg == 32'(GATE_CYC - 1)) begin
                    tmr_next   = '0;
                    state_next = WAIT_CNT;
                end else begin
                    tmr_next = tmr_reg + 32'd1;
                end
            end
            WAIT_CNT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (bus.cnt_valid) begin
                    x_next     = bus.cnt_test;
                    y_next     = bus.cnt_stand;
                    start_next = 1'b1;
                    state_next = DIV;
                end else if (tmr_reg == 32'(TIMEOUT_CYC - 1)) begin
                    freq_next  = '0;
                    err_next   = 1'b1;
                    ovf_next   = 1'b0;
                    state_next = OUT;
                end else begin
                    tmr_next = tmr_reg + 32'd1;
                end
            end
            DIV: begin
                if (!enable) begin
                    div_clear  = 1'b1;
                    state_next = IDLE;
                end else if (div_done) begin
                    if (div_zero) begin
                        freq_next = '0;
                        err_next  = 1'b1;
                        ovf_next  = 1'b0;
                    end else if (div_quo[NUM_W-1:FREQ_W] != '0) begin
                        freq_next = '1;
                        err_next  = 1'b0;
                        ovf_next  = 1'b1;
                    end else begin
                        freq_next = div_quo[FREQ_W-1:0];
                        err_next  = 1'b0;
                        ovf_next  = 1'b0;
                    end
                    state_next = OUT;
                end
            end
            OUT: begin
                // A dropped enable only takes effect once the pending result is taken.
                if (bus.res_ready) state_next = enable ? SELECT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            ch_sel_reg <= '0;
            tmr_reg    <= '0;
            x_reg      <= '0;
            y_reg      <= '0;
            freq_reg   <= '0;
            err_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
            start_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            ch_sel_reg <= ch_sel_next;
            tmr_reg    <= tmr_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            freq_reg   <= freq_next;
            err_reg    <= err_next;
            ovf_reg    <= ovf_next;
            start_reg  <= start_next;
        end
    end

    assign busy          = (state_reg != IDLE);
    assign bus.gate_open = (state_reg == GATE);
    assign bus.res_valid = (state_reg == OUT);
    assign bus.ch_sel    = ch_sel_reg;
    assign bus.res_ch    = ch_sel_reg;
    assign bus.res_freq  = freq_reg;
    assign bus.res_err   = err_reg;
    assign bus.res_ovf   = ovf_reg;

endmodule

// File: tb/tb_freq_meter_seq.sv
// Directed bench for freq_meter_seq with a small gate/count datapath model.
module tb_freq_meter_seq;

    localparam int NCH    = 4;
    localparam int CNT_W  = 48;
    localparam int FREQ_W = 34;

    logic           sys_clk = 1'b0;
    logic           sys_rst_n;
    logic           enable;
    logic [NCH-1:0] ch_mask;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    logic             model_silent = 1'b0;
    logic [CNT_W-1:0] model_x = 48'd500;
    logic [CNT_W-1:0] model_y = 48'd1000;
    int               cnt_pulses = 0;
    int               gate_run = 0;
    int               last_gate = 0;

    always #5 sys_clk = ~sys_clk;

    freq_meter_seq_if #(.NCH(NCH), .CNT_W(CNT_W), .FREQ_W(FREQ_W)) ifc ();

    freq_meter_seq #(
        .NCH            (NCH),
        .CNT_W          (CNT_W),
        .FREQ_W         (FREQ_W),
        .CLK_STAND_FREQ (100_000_000),
        .GATE_CYC       (1000),
        .SETTLE_CYC     (8),
        .TIMEOUT_CYC    (3000)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .enable    (enable),
        .ch_mask   (ch_mask),
        .busy      (busy),
        .bus       (ifc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Datapath model: counts become valid 5 cycles after every gate close.
    initial begin
        ifc.cnt_valid = 1'b0;
        ifc.cnt_test  = '0;
        ifc.cnt_stand = '0;
        forever begin
            @(negedge ifc.gate_open);
            repeat (5) @(negedge sys_clk);
            if (!model_silent) begin
                ifc.cnt_test  = model_x;
                ifc.cnt_stand = model_y;
                ifc.cnt_valid = 1'b1;
                cnt_pulses++;
                @(negedge sys_clk);
                ifc.cnt_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            if (ifc.gate_open === 1'b1) begin
                gate_run++;
            end else if (gate_run != 0) begin
                last_gate = gate_run;
                gate_run  = 0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_gate(input string tag);
        int waited = 0;
        while (ifc.gate_open !== 1'b1 && waited < 3000) begin
            @(negedge sys_clk);
            waited++;
        end
        check({tag, " gate_seen"}, ifc.gate_open, 1'b1);
    endtask

    task automatic expect_result(input string tag, input int exp_ch, input logic [FREQ_W-1:0] exp_freq,
                                 input logic exp_err, input logic exp_ovf, input bit chk_gate);
        int waited = 0;
        while (ifc.res_valid !== 1'b1 && waited < 8000) begin
            @(negedge sys_clk);
            waited++;
        end
        check({tag, " res_valid"}, ifc.res_valid, 1'b1);
        if (ifc.res_valid === 1'b1) begin
            check({tag, " res_ch"},   ifc.res_ch,   exp_ch);
            check({tag, " res_freq"}, ifc.res_freq, exp_freq);
            check({tag, " res_err"},  ifc.res_err,  exp_err);
            check({tag, " res_ovf"},  ifc.res_ovf,  exp_ovf);
            if (chk_gate) check({tag, " gate_len"}, last_gate, 1000);
            $display("result %s: ch=%0d freq=%0d err=%0b ovf=%0b gate=%0d",
                     tag, ifc.res_ch, ifc.res_freq, ifc.res_err, ifc.res_ovf, last_gate);
        end
    endtask

    task automatic accept(input string tag);
        ifc.res_ready = 1'b1;
        @(negedge sys_clk);
        ifc.res_ready = 1'b0;
        check({tag, " valid_after_hs"}, ifc.res_valid, 1'b0);
    endtask

    initial begin
        logic [FREQ_W-1:0] snap_freq;
        logic [1:0]        snap_ch;
        int                diffs;
        int                seen;
        int                pulses0;
        int                waited;

        sys_rst_n     = 1'b1;
        enable        = 1'b0;
        ch_mask       = '0;
        ifc.res_ready = 1'b0;
        #1 sys_rst_n  = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst flags", {busy, ifc.gate_open, ifc.res_valid, ifc.res_err, ifc.res_ovf}, 5'b0);
        check("rst ch", {ifc.ch_sel, ifc.res_ch}, 4'b0);
        check("rst freq", ifc.res_freq, 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Empty mask keeps the sequencer idle.
        enable  = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("mask0 busy", busy, 1'b0);

        // Round-robin over channels 0 and 2.
        ch_mask = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            expect_result("scan", (k % 2) * 2, 34'd50_000_000, 1'b0, 1'b0, 1'b1);
            if (k == 3) enable = 1'b0;
            accept("scan");
        end
        repeat (5) @(negedge sys_clk);
        check("disabled busy", busy, 1'b0);

        // No counts: timeout on channel 0, scan then advances to channel 2.
        model_silent = 1'b1;
        enable       = 1'b1;
        expect_result("timeout", 0, '0, 1'b1, 1'b0, 1'b0);
        model_silent = 1'b0;
        model_x      = 48'd1000;
        model_y      = 48'd0;
        accept("timeout");

        expect_result("y_zero", 2, '0, 1'b1, 1'b0, 1'b0);
        model_x = 48'h8000_0000_0000;
        model_y = 48'd1;
        accept("y_zero");

        expect_result("ovf", 0, 34'h3_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
        model_x = 48'd500;
        model_y = 48'd1000;
        accept("ovf");

        // Back-pressure: result must hold while res_ready stays low.
        expect_result("hold", 2, 34'd50_000_000, 1'b0, 1'b0, 1'b0);
        snap_freq = ifc.res_freq;
        snap_ch   = ifc.res_ch;
        diffs     = 0;
        repeat (50) begin
            @(negedge sys_clk);
            if (ifc.res_valid !== 1'b1 || ifc.res_freq !== snap_freq || ifc.res_ch !== snap_ch ||
                ifc.res_err !== 1'b0 || ifc.res_ovf !== 1'b0 || ifc.gate_open !== 1'b0 ||
                ifc.ch_sel !== snap_ch)
                diffs++;
        end
        check("hold stable", diffs, 0);
        accept("hold");

        // Mask change mid-gate only affects the next selection.
        wait_gate("mask_old");
        check("mask_old ch_sel", ifc.ch_sel, 2'd0);
        ch_mask = 4'b1000;
        expect_result("mask_old", 0, 34'd50_000_000, 1'b0, 1'b0, 1'b1);
        accept("mask_old");
        wait_gate("mask_new");
        check("mask_new ch_sel", ifc.ch_sel, 2'd3);
        expect_result("mask_new", 3, 34'd50_000_000, 1'b0, 1'b0, 1'b1);
        accept("mask_new");

        // Abort mid-gate.
        wait_gate("abort");
        repeat (100) @(negedge sys_clk);
        enable = 1'b0;
        @(negedge sys_clk);
        check("abort gate_open", ifc.gate_open, 1'b0);
        check("abort busy", busy, 1'b0);
        seen = 0;
        repeat (200) begin
            @(negedge sys_clk);
            if (ifc.res_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        check("abort quiet", seen, 0);

        // Reset while dividing on channel 2; the pointer must restart at 0.
        ch_mask = 4'b0100;
        enable  = 1'b1;
        pulses0 = cnt_pulses;
        waited  = 0;
        while (cnt_pulses == pulses0 && waited < 3000) begin
            @(negedge sys_clk);
            waited++;
        end
        check("div cnt_valid seen", cnt_pulses, pulses0 + 1);
        repeat (10) @(negedge sys_clk);
        check("in div busy", busy, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        check("midrst flags", {busy, ifc.gate_open, ifc.res_valid, ifc.res_err, ifc.res_ovf}, 5'b0);
        check("midrst ch_sel", ifc.ch_sel, 2'd0);
        check("midrst freq", ifc.res_freq, 0);
        @(negedge sys_clk);
        ch_mask   = 4'b1010;
        sys_rst_n = 1'b1;
        wait_gate("after_rst");
        check("after_rst ch_sel", ifc.ch_sel, 2'd1);
        expect_result("after_rst", 1, 34'd50_000_000, 1'b0, 1'b0, 1'b1);
        accept("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
